ones_run_scheduler: RTL
=======================

// Module: ones_run_scheduler
// PURPOSE
//  Shares one longest-run-of-ones scanner between two requesters of the 32-bit ALU.
//  Round-robin arbiter grants one operand. A bit-serial FSM then finds the longest
//  string of consecutive 1s in the full WIDTH-bit word, replacing the 8-bit
//  combinational ones-string unit for wide operands.
//  The result returns on a valid/ready channel, tagged with the requester id.
// PARAMETERS
//  WIDTH  32  operand width in bits, >= 2
//  CNT_W  6   result width, $clog2(WIDTH+1); must hold the value WIDTH
// PORTS
//  clk        in   1      system clock, all logic on rising edge
//  reset      in   1      synchronous, active-high reset
//  req0_valid in   1      requester 0 has an operand
//  req0_data  in   WIDTH  requester 0 operand
//  req0_ready out  1      requester 0 operand accepted this cycle
//  req1_valid in   1      requester 1 has an operand
//  req1_data  in   WIDTH  requester 1 operand
//  req1_ready out  1      requester 1 operand accepted this cycle
//  res_valid  out  1      result available
//  res_count  out  CNT_W  longest run of consecutive 1s in the accepted operand
//  res_id     out  1      requester that owns res_count
//  res_ready  in   1      consumer takes result
//  busy       out  1      high in SCAN or DONE
// BEHAVIOUR
//  - Reset (clk edge with reset=1): state=IDLE, res_valid=0, res_count=0, res_id=0,
//    busy=0, internal counters=0, last_grant=1, so requester 0 has priority next.
//  - States: IDLE -> SCAN -> DONE -> IDLE.
//  - IDLE, grant (combinational):
//    - only reqN_valid high: grant N.
//    - both high: grant !last_grant.
//    - reqN_ready = (state==IDLE) & grant==N & reqN_valid. At most one ready is
//      high. Both are 0 outside IDLE.
//  - Accept edge: operand goes into shift reg, res_id<=N, last_grant<=N,
//    cur=0, max=0, bit_idx=0, state<=SCAN.
//  - SCAN: one bit per cycle, LSB first, for WIDTH cycles (bit_idx 0..WIDTH-1).
//    - bit=1: cur<=cur+1; max<=max(max,cur+1).
//    - bit=0: cur<=0; max unchanged.
//    - Compare uses cur+1 at CNT_W width. No overflow is possible because
//      cur <= WIDTH.
//    - At the edge where bit_idx==WIDTH-1 is processed: state<=DONE,
//      res_count<=final max, res_valid<=1.
//  - Latency: accept at edge T; res_valid is high after edge T+WIDTH. This is
//    fixed and independent of the data.
//  - DONE: res_valid, res_count and res_id are held stable while res_ready=0.
//    With res_ready=1, at the next edge: res_valid<=0, state<=IDLE. res_count keeps
//    its last value.
//  - Throughput: with res_ready tied high, at most one operand per WIDTH+2 cycles.
//  - No new grant in SCAN or DONE. Requests stay pending and are not dropped.
//    The requester must hold valid and data stable until ready.
//  - reset mid-SCAN or mid-DONE: the operation is abandoned and no result is produced.
//    All reset values return on the next edge.
//  - Boundaries:
//    - all-zero operand -> 0.
//    - all-ones operand -> WIDTH.
//    - A run ending at the MSB counts, because max updates on the final bit.
// TESTING
//  - Directed vectors come from a file; the bench checks res_count/res_id on the
//    res_valid&res_ready cycle and reports the error count at the end.
//  - req0 0x00000000 -> res_count=0, res_id=0, res_valid exactly 32 cycles after accept.
//  - req1 0xFFFFFFFF -> 32. req0 0x80000001 -> 1. req0 0x00FFF000 -> 12.
//    req1 0xF0FF00FF -> 8. MSB run 0xFE000000 -> 7.
//  - Both valid from reset, 4 ops each, res_ready=1:
//    - grants alternate 0,1,0,1...
//    - each reqN_ready is a single-cycle pulse.
//    - ready never overlaps.
//  - res_ready=0 for 5 cycles in DONE:
//    - res_valid/count/id are held stable.
//    - no req ready.
//    - raising res_ready -> IDLE on the next edge.
//  - reset asserted at scan bit 10 of 0xFFFFFFFF:
//    - no res_valid follows.
//    - busy=0 after the edge.
//    - the next request from both requesters is granted to requester 0.

Source files
------------

// File: rtl/ones_run_scheduler.sv
// Round-robin shared scanner: grants one of two operands, then walks it LSB first
// and returns the longest run of consecutive 1s on a valid/ready channel.
module ones_run_scheduler #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   input  logic [WIDTH-1:0] req0_data,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [WIDTH-1:0] req1_data,
   output logic             req1_ready,
   output logic             res_valid,
   output logic [CNT_W-1:0] res_count,
   output logic             res_id,
   input  logic             res_ready,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] shift_reg;
   logic [CNT_W-1:0] cur_run;
   logic [CNT_W-1:0] max_run;
   logic [CNT_W-1:0] bit_idx;
   logic             last_grant;

   logic             grant;
   logic             accept;
   logic [CNT_W-1:0] cur_inc;
   logic [CNT_W-1:0] next_max;

   // With both requesting, the side not served last wins; otherwise whoever asks.
   always_comb begin
      grant = 1'b0;
      if (req0_valid && req1_valid)
         grant = ~last_grant;
      else if (req1_valid)
         grant = 1'b1;
   end

   assign req0_ready = (state == IDLE) && !grant && req0_valid;
   assign req1_ready = (state == IDLE) &&  grant && req1_valid;
   assign accept     = req0_ready || req1_ready;
   assign busy       = (state != IDLE);

   // Max including the bit in flight, so a run ending at the MSB is counted.
   always_comb begin
      cur_inc  = cur_run + 1'b1;
      next_max = max_run;
      if (shift_reg[0] && (cur_inc > max_run))
         next_max = cur_inc;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         shift_reg  <= '0;
         cur_run    <= '0;
         max_run    <= '0;
         bit_idx    <= '0;
         last_grant <= 1'b1;
         res_valid  <= 1'b0;
         res_count  <= '0;
         res_id     <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  shift_reg  <= grant ? req1_data : req0_data;
                  res_id     <= grant;
                  last_grant <= grant;
                  cur_run    <= '0;
                  max_run    <= '0;
                  bit_idx    <= '0;
                  state      <= SCAN;
               end
            end
            SCAN: begin
               shift_reg <= shift_reg >> 1;
               cur_run   <= shift_reg[0] ? cur_inc : '0;
               max_run   <= next_max;
               bit_idx   <= bit_idx + 1'b1;
               if (bit_idx == LAST_IDX) begin
                  res_count <= next_max;
                  res_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
